// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 device-to-host receiver.
//   - ps2_state_t     : frame state machine encoding
//   - PS2_DATA_BITS   : payload bits per frame
//   - PS2_FILTER_LEN  : default clock de-glitch length (board clock)
//   - PS2_TIMEOUT_CYCLES : default mid-frame timeout (1 ms at 50 MHz)
package ps2_pkg;

   localparam int PS2_DATA_BITS      = 8;
   localparam int PS2_FILTER_LEN     = 4;
   localparam int PS2_TIMEOUT_CYCLES = 50000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, debounce filter and falling-edge
// detector for the raw PS/2 clock pin.
// Ports:
//   clk  in   board clock
//   rst  in   synchronous active-high reset
//   pin  in   raw asynchronous pin
//   fall out  one-cycle pulse in the cycle the filtered level becomes 0
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = PS2_FILTER_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic fall
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);

   logic [1:0]       sync_chain;
   logic             filt;
   logic [CNT_W-1:0] cnt;

   // NOTE: every clocked state update uses <= so all flops sample the
   // values from before the edge; = here would collapse the sync chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         // Idle bus is high, so the chain, filter and counter preset to 1.
         sync_chain <= 2'b11;
         filt       <= 1'b1;
         cnt        <= CNT_W'(1);
         fall       <= 1'b0;
      end else begin
         sync_chain <= {sync_chain[0], pin};
         fall       <= 1'b0;
         if (sync_chain[1] != filt) begin
            // Adopt the new level only after FILTER_LEN consecutive
            // disagreeing samples; any agreeing sample restarts the count.
            if (cnt == CNT_W'(FILTER_LEN - 1)) begin
               filt <= sync_chain[1];
               cnt  <= '0;
               fall <= filt;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver (start, 8 data LSB
// first, odd parity, stop). Delivers one byte per good frame.
// Ports:
//   CLK        in   board clock
//   RST        in   synchronous active-high reset
//   PS2_CLK    in   raw keyboard clock pin (asynchronous)
//   PS2_DATA   in   raw keyboard data pin (asynchronous)
//   DATA_OUT   out  last valid received byte
//   DATA_VALID out  one-cycle strobe, DATA_OUT updated this cycle
//   FRAME_ERR  out  one-cycle strobe, frame discarded
//   BUSY       out  high while a frame is in progress
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = PS2_FILTER_LEN,
   parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic [7:0] DATA_OUT,
   output logic       DATA_VALID,
   output logic       FRAME_ERR,
   output logic       BUSY
);

   localparam int BIT_W = $clog2(PS2_DATA_BITS);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   ps2_state_t         state, state_nx;
   logic [BIT_W-1:0]   bit_cnt, bit_cnt_nx;
   logic [7:0]         shreg, shreg_nx;
   logic               par, par_nx;
   logic [TMO_W-1:0]   tmo_cnt, tmo_nx;
   logic [7:0]         dout_nx;
   logic               valid_nx, err_nx;
   logic [1:0]         data_sync;
   logic               data_s;
   logic               fall;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk  (CLK),
      .rst  (RST),
      .pin  (PS2_CLK),
      .fall (fall)
   );

   assign data_s = data_sync[1];
   assign BUSY   = (state != IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         data_sync  <= 2'b11;
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         tmo_cnt    <= '0;
         DATA_OUT   <= 8'h00;
         DATA_VALID <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         data_sync  <= {data_sync[0], PS2_DATA};
         state      <= state_nx;
         bit_cnt    <= bit_cnt_nx;
         shreg      <= shreg_nx;
         par        <= par_nx;
         tmo_cnt    <= tmo_nx;
         DATA_OUT   <= dout_nx;
         DATA_VALID <= valid_nx;
         FRAME_ERR  <= err_nx;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path
      // leaves one unassigned and infers a latch.
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      shreg_nx   = shreg;
      par_nx     = par;
      dout_nx    = DATA_OUT;
      valid_nx   = 1'b0;
      err_nx     = 1'b0;
      tmo_nx     = (state == IDLE || fall) ? '0 : tmo_cnt + 1'b1;

      if (fall) begin
         // A fall event always wins over a simultaneous timeout.
         unique case (state)
            IDLE: begin
               if (!data_s) begin
                  state_nx   = DATA;
                  bit_cnt_nx = '0;
               end else begin
                  err_nx = 1'b1;
               end
            end
            DATA: begin
               shreg_nx   = {data_s, shreg[7:1]};
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == BIT_W'(PS2_DATA_BITS - 1))
                  state_nx = PARITY;
            end
            PARITY: begin
               par_nx   = data_s;
               state_nx = STOP;
            end
            STOP: begin
               // Odd parity: data bits plus parity bit hold an odd count of ones.
               if (data_s && ((^shreg) ^ par)) begin
                  dout_nx  = shreg;
                  valid_nx = 1'b1;
               end else begin
                  err_nx = 1'b1;
               end
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end else if (state != IDLE && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
         state_nx = IDLE;
         err_nx   = 1'b1;
         tmo_nx   = '0;
      end
   end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed bench for ps2_frame_rx. The PS/2 clock and the
// timeout are scaled down (40-cycle PS/2 bit period, 400-cycle timeout) so
// every scenario fits in a short run; ratios match the real board.
module tb_ps2_frame_rx;
   import ps2_pkg::*;

   localparam int TMO  = 400;
   localparam int HALF = 20;

   logic       CLK      = 1'b0;
   logic       RST      = 1'b1;
   logic       PS2_CLK  = 1'b1;
   logic       PS2_DATA = 1'b1;
   logic [7:0] DATA_OUT;
   logic       DATA_VALID;
   logic       FRAME_ERR;
   logic       BUSY;

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] exp_dout = 8'h00;
   int         total = 0;
   int         bad   = 0;

   always #5 CLK = ~CLK;

   ps2_frame_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .PS2_CLK    (PS2_CLK),
      .PS2_DATA   (PS2_DATA),
      .DATA_OUT   (DATA_OUT),
      .DATA_VALID (DATA_VALID),
      .FRAME_ERR  (FRAME_ERR),
      .BUSY       (BUSY)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
      end
   endtask

   // Scoreboard consumer: every strobe must match the next expected event.
   always @(negedge CLK) begin
      exp_t e;
      if (!RST && (DATA_VALID || FRAME_ERR)) begin
         check("strobe_exclusive", {31'b0, DATA_VALID & FRAME_ERR}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {30'b0, DATA_VALID, FRAME_ERR}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("frame_err", {31'b0, FRAME_ERR}, {31'b0, e.is_err});
            check("data_valid", {31'b0, DATA_VALID}, {31'b0, ~e.is_err});
            if (!e.is_err) exp_dout = e.data;
            check("data_out", {24'b0, DATA_OUT}, {24'b0, exp_dout});
         end
      end
   end

   function automatic logic odd_par(input logic [7:0] d);
      return ~^d;
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic push(input logic is_err, input logic [7:0] d);
      exp_t e;
      e.is_err = is_err;
      e.data   = d;
      exp_q.push_back(e);
   endtask

   // Sends bits[0..n-1]; data changes while the clock is high. Optional
   // 2-cycle low glitch in the high phase after bit glitch_at.
   task automatic send_bits(input logic [10:0] bits, input int n,
                            input bit chk_busy, input int glitch_at);
      for (int i = 0; i < n; i++) begin
         PS2_DATA = bits[i];
         wait_cyc(HALF / 2);
         PS2_CLK = 1'b0;
         wait_cyc(HALF / 2);
         if (chk_busy)
            check($sformatf("busy_bit%0d", i), {31'b0, BUSY}, (i < 10) ? 32'd1 : 32'd0);
         wait_cyc(HALF / 2);
         PS2_CLK = 1'b1;
         if (i == glitch_at) begin
            wait_cyc(3);
            PS2_CLK = 1'b0;
            wait_cyc(2);
            PS2_CLK = 1'b1;
            wait_cyc(HALF / 2 - 5);
         end else begin
            wait_cyc(HALF / 2);
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                             input bit chk_busy, input int glitch_at);
      send_bits({stop, p, d, 1'b0}, 11, chk_busy, glitch_at);
   endtask

   task automatic drain(input int bound);
      int k = 0;
      while (exp_q.size() != 0 && k < bound) begin
         @(negedge CLK);
         k++;
      end
      check("drain_timeout", exp_q.size(), 32'd0);
   endtask

   initial begin
      // Reset state
      wait_cyc(5);
      check("rst_data_out", {24'b0, DATA_OUT}, 32'h00);
      check("rst_data_valid", {31'b0, DATA_VALID}, 32'd0);
      check("rst_frame_err", {31'b0, FRAME_ERR}, 32'd0);
      check("rst_busy", {31'b0, BUSY}, 32'd0);
      RST = 1'b0;
      wait_cyc(10);

      // Single good frame 0x1C with BUSY tracking
      push(1'b0, 8'h1C);
      send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b1, -1);
      drain(200);

      // Back-to-back frames
      push(1'b0, 8'hF0);
      push(1'b0, 8'h1C);
      send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0, -1);
      send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0, -1);
      drain(200);

      // Parity error, then recovery
      push(1'b1, 8'h00);
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0, -1);
      drain(200);
      push(1'b0, 8'h29);
      send_frame(8'h29, odd_par(8'h29), 1'b1, 1'b0, -1);
      drain(200);

      // Stop bit low
      push(1'b1, 8'h00);
      send_frame(8'h75, 1'b0, 1'b0, 1'b0, -1);
      drain(200);

      // Bad start bit in IDLE
      push(1'b1, 8'h00);
      send_bits(11'h7FF, 1, 1'b0, -1);
      drain(200);
      check("busy_after_bad_start", {31'b0, BUSY}, 32'd0);

      // Timeout after start + 5 data bits, then a good frame
      push(1'b1, 8'h00);
      send_bits({1'b1, 1'b0, 8'h6B, 1'b0}, 6, 1'b0, -1);
      PS2_DATA = 1'b1;
      check("busy_mid_partial", {31'b0, BUSY}, 32'd1);
      drain(TMO + 100);
      check("busy_after_timeout", {31'b0, BUSY}, 32'd0);
      push(1'b0, 8'h6B);
      send_frame(8'h6B, odd_par(8'h6B), 1'b1, 1'b0, -1);
      drain(200);

      // Short clock glitch mid-frame is ignored
      push(1'b0, 8'h1C);
      send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0, 3);
      drain(200);

      // Reset mid-frame after bit 4
      send_bits({odd_par(8'h74), 8'h74, 1'b0} | 11'h400, 5, 1'b0, -1);
      check("busy_before_reset", {31'b0, BUSY}, 32'd1);
      RST = 1'b1;
      wait_cyc(3);
      check("busy_in_reset", {31'b0, BUSY}, 32'd0);
      check("data_out_in_reset", {24'b0, DATA_OUT}, 32'h00);
      exp_dout = 8'h00;
      RST = 1'b0;
      PS2_DATA = 1'b1;
      wait_cyc(50);
      push(1'b0, 8'h74);
      send_frame(8'h74, odd_par(8'h74), 1'b1, 1'b0, -1);
      drain(200);

      wait_cyc(50);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
